slot4_loader: RTL and testbench
===============================

Name: slot4_loader

Overview:
- Four-slot word assembler. Sits directly downstream of the 1-to-4 select-demultiplexer and enable-gated flop storage in the register path.
- Accepts a stream of WIDTH-bit items over a valid/ready handshake and steers each item into slot 0..3 using an internal 2-bit write pointer. The pointer's one-hot decode acts as per-slot write enables.
- Presents the assembled 4*WIDTH-bit word over an output valid/ready handshake.

Parameters:
- WIDTH, 1, bits per slot/item (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- clear  input  1  synchronous clear. Pointer to 0, slots to 0, out_valid to 0.
- in_valid  input  1  input item available.
- in_ready  output  1  block can accept an item this cycle.
- in_data  input  WIDTH  input item.
- out_valid  output  1  assembled word available.
- out_ready  input  1  consumer accepts word this cycle.
- out_data  output  4*WIDTH  slot3..slot0 concatenated; slot0 in LSBs.
- wr_ptr  output  2  current write slot index (debug/observe).

Behaviour:
- Reset (reset=0, asynchronous): state=FILL, wr_ptr=0, all slots=0, out_valid=0, out_data=0. in_ready is 1 once reset deasserts.
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- State FILL:
  - in_ready=1, out_valid=0.
  - On in_fire: slot[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 (mod 4). No other slot changes.
  - If in_fire with wr_ptr==3: wr_ptr wraps to 0 and state <= FULL next cycle.
- State FULL:
  - out_valid=1; out_data stable until out_fire.
  - in_ready = out_ready (pass-through acceptance).
  - out_fire without in_fire: state <= FILL, wr_ptr stays 0.
  - out_fire with in_fire (same cycle): word is consumed; slot0 <= in_data, wr_ptr <= 1, state <= FILL.
  - No out_fire: hold; in_ready=0; in_data ignored.
- Latency: the 4th accepted item gives out_valid=1 on the next rising edge. Back-to-back throughput is one item per cycle, sustained when out_ready=1.
- Slots not yet rewritten in FILL keep old contents. out_data is still driven in FILL but is only meaningful when out_valid=1.
- clear=1 (synchronous): overrides all handshakes that cycle. Next cycle: FILL, wr_ptr=0, slots=0, out_valid=0. in_ready stays combinationally 1 while clear is high.
- Asynchronous reset mid-word or while FULL: the partial or pending word is discarded immediately and outputs go to reset values.
- in_valid with X/idle data while in_ready=0 must not change state.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready in FULL only.

Optional Feature:
- Macro: SLOT4_LOADER_FLUSH_EN.
- With the macro defined:
  - Adds input in_last (1), valid only with in_fire.
  - Adds output out_mask (4), bit k = slot k written for this word.
  - in_fire with in_last=1 in FILL writes the item and then forces state FULL regardless of wr_ptr, with wr_ptr <= 0.
  - out_mask marks exactly the slots written since the last word. Unwritten slots read 0 in out_data.
  - out_mask=4'b1111 for a normal full word. Reset value of out_mask is 0.
- Without the macro: no in_last/out_mask ports; words are emitted only after exactly 4 items.

Test Plan:
- Reset, then push items 1,0,1,1 (WIDTH=1, out_ready=1) -> out_valid=1 on the cycle after the 4th item, out_data=4'b1101, then returns to FILL with wr_ptr=0.
- WIDTH=8, push 0x11,0x22,0x33,0x44 with out_ready=0 for 3 cycles, in_valid held with 0x55 -> out_data=0x44332211 stable, in_ready=0, 0x55 not accepted. Raise out_ready -> 0x55 lands in slot0, wr_ptr=1.
- Continuous in_valid=1 and out_ready=1 over 16 items 0..15 (WIDTH=4) -> 4 words 0x3210, 0x7654, 0xBA98, 0xFEDC, with no lost or duplicated items.
- Push 2 items, then assert clear for 1 cycle -> wr_ptr=0, out_valid=0, slots=0. The next 4 items form a fresh word.
- Drive reset=0 asynchronously mid-cycle while FULL -> out_valid drops before the next clock edge, and all outputs are 0.
- With SLOT4_LOADER_FLUSH_EN defined: push 0xAA, then 0xBB with in_last=1 -> out_valid=1, out_mask=4'b0011, out_data=0x0000BBAA.

Source files
------------

// File: rtl/slot4_loader.sv
// -----------------------------------------------------------------------------
// slot4_loader
//
// Four-slot word assembler. Items of WIDTH bits arrive over a valid/ready
// handshake and are steered into slot 0..3 by an internal 2-bit write pointer
// whose one-hot decode forms the per-slot write enables. Once four items are
// held the assembled word {slot3,slot2,slot1,slot0} is presented over an
// output valid/ready handshake. While the word is pending, acceptance of a new
// item is passed through from out_ready so that a consumed word and the first
// item of the next word can transfer in the same cycle (one item per cycle
// sustained).
//
// Optional build macro: SLOT4_LOADER_FLUSH_EN
//   Adds in_last / out_mask. An item accepted with in_last=1 closes the word
//   early; out_mask flags which slots belong to the current word and slots
//   outside the mask read as zero on out_data.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clear      synchronous clear (pointer, slots, out_valid to 0)
//   in_valid   input item available
//   in_ready   block can accept an item this cycle
//   in_data    input item, WIDTH bits
//   out_valid  assembled word available
//   out_ready  consumer accepts the word this cycle
//   out_data   slot3..slot0 concatenated, slot0 in the LSBs
//   wr_ptr     current write slot index
//   in_last    (flush build) item closes the current word
//   out_mask   (flush build) bit k set when slot k was written for this word
// -----------------------------------------------------------------------------
module slot4_loader #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [1:0]         wr_ptr
`ifdef SLOT4_LOADER_FLUSH_EN
    ,
    input  logic               in_last,
    output logic [3:0]         out_mask
`endif
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       wr_ptr_r;
    logic [1:0]       wr_ptr_nxt_s;
    logic [WIDTH-1:0] slot_r [4];
    logic [3:0]       slot_we_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             last_s;

    // One-hot decode of a slot index into per-slot write enables.
    function automatic logic [3:0] slot_decode(input logic [1:0] idx);
        logic [3:0] onehot;
        case (idx)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

`ifdef SLOT4_LOADER_FLUSH_EN
    logic [3:0] mask_r;
    logic [3:0] mask_nxt_s;
    assign last_s = in_last;
`else
    assign last_s = 1'b0;
`endif

    // Handshake decode. in_ready is held low while reset is asserted so every
    // output sits at zero during reset; clear forces acceptance high because
    // it overrides the handshake that cycle anyway.
    always_comb begin
        out_valid_s = (state_r == ST_FULL);
        in_ready_s  = reset & (clear | (state_r == ST_FILL) | out_ready);
        in_fire_s   = in_valid & in_ready_s;
        out_fire_s  = out_valid_s & out_ready;
    end

    // Next-state, next-pointer and slot write-enable logic.
    always_comb begin
        state_nxt_s  = state_r;
        wr_ptr_nxt_s = wr_ptr_r;
        slot_we_s    = 4'b0000;
        case (state_r)
            ST_FILL: begin
                if (in_fire_s) begin
                    slot_we_s    = slot_decode(wr_ptr_r);
                    wr_ptr_nxt_s = wr_ptr_r + 2'd1;
                    if ((wr_ptr_r == 2'd3) || last_s) begin
                        state_nxt_s  = ST_FULL;
                        wr_ptr_nxt_s = 2'd0;
                    end else begin
                        state_nxt_s  = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_FULL: begin
                // in_fire can only happen here together with out_fire, since
                // in_ready follows out_ready while a word is pending.
                if (out_fire_s) begin
                    if (in_fire_s) begin
                        slot_we_s = 4'b0001;
                        if (last_s) begin
                            state_nxt_s  = ST_FULL;
                            wr_ptr_nxt_s = 2'd0;
                        end else begin
                            state_nxt_s  = ST_FILL;
                            wr_ptr_nxt_s = 2'd1;
                        end
                    end else begin
                        state_nxt_s  = ST_FILL;
                        wr_ptr_nxt_s = 2'd0;
                    end
                end else begin
                    state_nxt_s  = ST_FULL;
                    wr_ptr_nxt_s = wr_ptr_r;
                end
            end
            default: begin
                state_nxt_s  = ST_FILL;
                wr_ptr_nxt_s = 2'd0;
            end
        endcase
    end

    // State and write-pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_FILL;
            wr_ptr_r <= 2'd0;
        end else if (clear) begin
            state_r  <= ST_FILL;
            wr_ptr_r <= 2'd0;
        end else begin
            state_r  <= state_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
        end
    end

    // Slot storage; only the slot selected by the write enable changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clear) begin
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (slot_we_s[i]) begin
                    slot_r[i] <= in_data;
                end else begin
                    slot_r[i] <= slot_r[i];
                end
            end
        end
    end

`ifdef SLOT4_LOADER_FLUSH_EN
    // Written-slot mask: accumulates while filling, restarts when a word is
    // consumed (seeded with slot 0 if the next word's first item arrives in
    // the same cycle).
    always_comb begin
        mask_nxt_s = mask_r;
        if (state_r == ST_FILL) begin
            mask_nxt_s = mask_r | slot_we_s;
        end else if (out_fire_s) begin
            mask_nxt_s = slot_we_s;
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // Mask register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_r <= 4'b0000;
        end else if (clear) begin
            mask_r <= 4'b0000;
        end else begin
            mask_r <= mask_nxt_s;
        end
    end

    // Word output with slots outside the current word forced to zero.
    always_comb begin
        out_data = {(4*WIDTH){1'b0}};
        for (int k = 0; k < 4; k++) begin
            out_data[k*WIDTH +: WIDTH] = slot_r[k] & {WIDTH{mask_r[k]}};
        end
    end

    assign out_mask = mask_r;
`else
    // Word output straight from the slot registers.
    always_comb begin
        out_data = {slot_r[3], slot_r[2], slot_r[1], slot_r[0]};
    end
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign wr_ptr    = wr_ptr_r;

endmodule

// File: tb/tb_slot4_loader.sv
// -----------------------------------------------------------------------------
// tb_slot4_loader
//
// Directed bench for slot4_loader. Two instances share clock, reset and clear:
// d1 (WIDTH=1) and d8 (WIDTH=8). Inputs are driven 1 time unit after the
// rising edge and outputs are sampled there as well, away from the edge.
// Build with SLOT4_LOADER_FLUSH_EN defined to include the early-flush steps.
// -----------------------------------------------------------------------------
module tb_slot4_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;

    logic        iv1, ir1, ov1, or1;
    logic [0:0]  id1;
    logic [3:0]  od1;
    logic [1:0]  wp1;

    logic        iv8, ir8, ov8, or8;
    logic [7:0]  id8;
    logic [31:0] od8;
    logic [1:0]  wp8;

`ifdef SLOT4_LOADER_FLUSH_EN
    logic        il1, il8;
    logic [3:0]  om1, om8;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    slot4_loader #(.WIDTH(1)) d1 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .in_data   (id1),
        .out_valid (ov1),
        .out_ready (or1),
        .out_data  (od1),
        .wr_ptr    (wp1)
`ifdef SLOT4_LOADER_FLUSH_EN
        ,
        .in_last   (il1),
        .out_mask  (om1)
`endif
    );

    slot4_loader #(.WIDTH(8)) d8 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_data   (id8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_data  (od8),
        .wr_ptr    (wp8)
`ifdef SLOT4_LOADER_FLUSH_EN
        ,
        .in_last   (il8),
        .out_mask  (om8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_word;
        int          words;

        reset = 1'b0; clear = 1'b0;
        iv1 = 1'b0; id1 = 1'b0; or1 = 1'b0;
        iv8 = 1'b0; id8 = 8'h00; or8 = 1'b0;
`ifdef SLOT4_LOADER_FLUSH_EN
        il1 = 1'b0; il8 = 1'b0;
`endif

        // ---- reset state ----
        #12;
        chk("rst_out_valid", {31'd0, ov8}, 32'd0);
        chk("rst_out_data",  od8, 32'd0);
        chk("rst_wr_ptr",    {30'd0, wp8}, 32'd0);
        chk("rst_in_ready",  {31'd0, ir8}, 32'd0);
`ifdef SLOT4_LOADER_FLUSH_EN
        chk("rst_out_mask",  {28'd0, om8}, 32'd0);
`endif
        step();
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready8", {31'd0, ir8}, 32'd1);
        chk("post_rst_in_ready1", {31'd0, ir1}, 32'd1);

        // ---- WIDTH=1: items 1,0,1,1 -> 4'b1101 ----
        or1 = 1'b1;
        iv1 = 1'b1;
        id1 = 1'b1; step();
        chk("w1_ptr_after1", {30'd0, wp1}, 32'd1);
        chk("w1_not_valid",  {31'd0, ov1}, 32'd0);
        id1 = 1'b0; step();
        id1 = 1'b1; step();
        id1 = 1'b1; step();
        iv1 = 1'b0;
        chk("w1_out_valid", {31'd0, ov1}, 32'd1);
        chk("w1_out_data",  {28'd0, od1}, 32'h0000000D);
        chk("w1_wr_ptr",    {30'd0, wp1}, 32'd0);
        step();
        chk("w1_back_fill",  {31'd0, ov1}, 32'd0);
        chk("w1_ptr_zero",   {30'd0, wp1}, 32'd0);

        // ---- WIDTH=8: backpressure holds the word, 0x55 waits ----
        or8 = 1'b0;
        iv8 = 1'b1;
        id8 = 8'h11; step();
        id8 = 8'h22; step();
        id8 = 8'h33; step();
        id8 = 8'h44; step();
        id8 = 8'h55;
        #1;
        chk("bp_out_valid", {31'd0, ov8}, 32'd1);
        chk("bp_out_data",  od8, 32'h44332211);
        chk("bp_in_ready",  {31'd0, ir8}, 32'd0);
`ifdef SLOT4_LOADER_FLUSH_EN
        chk("bp_out_mask",  {28'd0, om8}, 32'h0000000F);
`endif
        step(); step(); step();
        chk("bp_hold_data",  od8, 32'h44332211);
        chk("bp_hold_valid", {31'd0, ov8}, 32'd1);
        chk("bp_hold_ptr",   {30'd0, wp8}, 32'd0);
        or8 = 1'b1;
        #1;
        chk("bp_passthru_ready", {31'd0, ir8}, 32'd1);
        step();
        chk("bp_after_valid", {31'd0, ov8}, 32'd0);
        chk("bp_after_ptr",   {30'd0, wp8}, 32'd1);
`ifndef SLOT4_LOADER_FLUSH_EN
        chk("bp_slot0_55",    od8, 32'h44332255);
`else
        chk("bp_slot0_55",    od8, 32'h00000055);
        chk("bp_mask_0001",   {28'd0, om8}, 32'h00000001);
`endif

        // ---- clear after a partial word ----
        id8 = 8'h66; step();
        chk("clr_pre_ptr", {30'd0, wp8}, 32'd2);
        clear = 1'b1;
        id8   = 8'h77;
        #1;
        chk("clr_in_ready", {31'd0, ir8}, 32'd1);
        step();
        clear = 1'b0;
        iv8   = 1'b0;
        chk("clr_ptr",   {30'd0, wp8}, 32'd0);
        chk("clr_valid", {31'd0, ov8}, 32'd0);
        chk("clr_data",  od8, 32'd0);
        iv8 = 1'b1;
        or8 = 1'b0;
        id8 = 8'hA1; step();
        id8 = 8'hA2; step();
        id8 = 8'hA3; step();
        id8 = 8'hA4; step();
        iv8 = 1'b0;
        chk("clr_fresh_valid", {31'd0, ov8}, 32'd1);
        chk("clr_fresh_data",  od8, 32'hA4A3A2A1);
        or8 = 1'b1;
        step();
        chk("clr_fresh_consumed", {31'd0, ov8}, 32'd0);

        // ---- streaming 16 items, out_ready=1 throughout ----
        words = 0;
        iv8 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            id8 = 8'(k);
            #1;
            chk("stream_in_ready", {31'd0, ir8}, 32'd1);
            step();
            if (k % 4 == 3) begin
                exp_word = {8'(4*words+3), 8'(4*words+2), 8'(4*words+1), 8'(4*words)};
                chk("stream_valid", {31'd0, ov8}, 32'd1);
                chk("stream_word",  od8, exp_word);
                words++;
            end else begin
                chk("stream_idle", {31'd0, ov8}, 32'd0);
            end
        end
        iv8 = 1'b0;
        chk("stream_word_count", 32'(words), 32'd4);
        step();
        chk("stream_end_valid", {31'd0, ov8}, 32'd0);
        chk("stream_end_ptr",   {30'd0, wp8}, 32'd0);

`ifdef SLOT4_LOADER_FLUSH_EN
        // ---- early flush: 0xAA then 0xBB with in_last ----
        or8 = 1'b0;
        iv8 = 1'b1;
        id8 = 8'hAA; il8 = 1'b0; step();
        id8 = 8'hBB; il8 = 1'b1; step();
        iv8 = 1'b0; il8 = 1'b0;
        chk("flush_valid", {31'd0, ov8}, 32'd1);
        chk("flush_mask",  {28'd0, om8}, 32'h00000003);
        chk("flush_data",  od8, 32'h0000BBAA);
        chk("flush_ptr",   {30'd0, wp8}, 32'd0);
        or8 = 1'b1;
        step();
        chk("flush_consumed", {31'd0, ov8}, 32'd0);
        chk("flush_mask_clr", {28'd0, om8}, 32'd0);
`endif

        // ---- asynchronous reset while FULL ----
        or8 = 1'b0;
        iv8 = 1'b1;
        id8 = 8'hC0; step();
        id8 = 8'hC1; step();
        id8 = 8'hC2; step();
        id8 = 8'hC3; step();
        iv8 = 1'b0;
        chk("ar_full_valid", {31'd0, ov8}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid_drop", {31'd0, ov8}, 32'd0);
        chk("ar_data_zero",  od8, 32'd0);
        chk("ar_ptr_zero",   {30'd0, wp8}, 32'd0);
        chk("ar_ready_zero", {31'd0, ir8}, 32'd0);
        step();
        reset = 1'b1;
        #1;
        chk("ar_release_ready", {31'd0, ir8}, 32'd1);
        chk("ar_release_valid", {31'd0, ov8}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
